calc_rhythm_phase_mb: RTL and testbench

//  Multi-bank rhythm phase transform between the phase generator (p2) and the sine/envelope stage (p3).
//  Hi-hat, snare drum and top-cymbal slots get the OPL3 rhythm phase formulas; all other slots pass through unchanged.

---
 rtl/opl3_pkg.sv | 25 ++
 rtl/calc_rhythm_phase_mb_lfsr.sv | 42 ++++
 rtl/pipeline_sr.sv | 34 +++
 rtl/calc_rhythm_phase_mb.sv | 179 +++++++++++++++++
 tb/tb_calc_rhythm_phase_mb.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/opl3_pkg.sv
// opl3_pkg: OPL3 pipeline widths, operator slot types and the rhythm mixing helper.
package opl3_pkg;

  localparam int PHASE_FINAL_WIDTH = 10;
  // Two bits leave room for up to four banks and for out-of-range bank numbers.
  localparam int BANK_NUM_WIDTH = 2;
  localparam int OP_NUM_WIDTH = 5;
  localparam int unsigned DEFAULT_RHYTHM_POLY = 32'h800302;

  typedef enum logic [2:0] {
    OP_NORMAL,
    OP_BASS_DRUM,
    OP_HI_HAT,
    OP_TOM_TOM,
    OP_SNARE_DRUM,
    OP_TOP_CYMBAL
  } operator_t;

  // Shared hi-hat / top-cymbal mixing term built from phase bit pairs of both friends.
  function automatic logic rhythm_mix(input logic [PHASE_FINAL_WIDTH-1:0] hh,
                                      input logic [PHASE_FINAL_WIDTH-1:0] tc);
    return (hh[2] ^ hh[7]) | (hh[3] ^ tc[5]) | (tc[3] ^ tc[5]);
  endfunction

endpackage

// File: rtl/calc_rhythm_phase_mb_lfsr.sv
// rhythm_noise_lfsr: Galois noise LFSR for rhythm slots; a zero seed is promoted to 1 to avoid lock-up.
module rhythm_noise_lfsr
  import opl3_pkg::*;
#(
  parameter int unsigned POLY  = DEFAULT_RHYTHM_POLY,
  parameter int          WIDTH = $clog2(POLY),
  parameter int unsigned SEED  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step,
  input  logic             load,
  output logic [WIDTH-1:0] state
);

  localparam logic [WIDTH-1:0] POLY_W = WIDTH'(POLY);
  localparam logic [WIDTH-1:0] SEED_W = (WIDTH'(SEED) == '0) ? WIDTH'(1) : WIDTH'(SEED);

  logic [WIDTH-1:0] state_reg;
  logic [WIDTH-1:0] state_next;

  // Load wins over a coincident step.
  always_comb begin
    state_next = state_reg;
    if (load) begin
      state_next = SEED_W;
    end else if (step) begin
      state_next = state_reg[0] ? ((state_reg ^ POLY_W) >> 1) : (state_reg >> 1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= SEED_W;
    end else begin
      state_reg <= state_next;
    end
  end

  assign state = state_reg;

endmodule

// File: rtl/pipeline_sr.sv
// pipeline_sr: DEPTH-stage register delay line with asynchronous reset to RESET_VAL.
module pipeline_sr #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH+1];

  assign stage[0] = din;

  genvar gi;
  for (gi = 0; gi < DEPTH; gi++) begin : gen_stage
    logic [WIDTH-1:0] stage_reg;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        stage_reg <= RESET_VAL;
      end else begin
        stage_reg <= stage[gi];
      end
    end

    assign stage[gi+1] = stage_reg;
  end

  assign dout = stage[DEPTH];

endmodule

// File: rtl/calc_rhythm_phase_mb.sv
// calc_rhythm_phase_mb: multi-bank OPL3 rhythm phase transform between the phase generator (p2)
// and the sine/envelope stage (p3). Hi-hat, snare and top-cymbal slots are rewritten; others pass.
module calc_rhythm_phase_mb
  import opl3_pkg::*;
#(
  parameter int          NUM_BANKS   = 2,
  parameter int unsigned LFSR_POLY   = DEFAULT_RHYTHM_POLY,
  parameter int          LFSR_WIDTH  = $clog2(LFSR_POLY),
  parameter int unsigned LFSR_SEED   = 1,
  parameter bit          SHARED_LFSR = 1'b1,
  parameter int          HH_OP       = 13,
  parameter int          TC_OP       = 17
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         sample_clk_en,
  input  logic [BANK_NUM_WIDTH-1:0]    bank_num,
  input  logic [OP_NUM_WIDTH-1:0]      op_num,
  input  operator_t                    op_type_p0,
  input  logic [PHASE_FINAL_WIDTH-1:0] phase_p2,
  input  logic [NUM_BANKS-1:0]         rhythm_en,
  input  logic                         seed_load,
  output logic [PHASE_FINAL_WIDTH-1:0] rhythm_phase_p3,
  output logic                         noise_bit_p3
);

  localparam int NUM_LFSR   = SHARED_LFSR ? 1 : NUM_BANKS;
  localparam int TYPE_WIDTH = $bits(operator_t);
  localparam int CTRL_WIDTH = 1 + BANK_NUM_WIDTH + OP_NUM_WIDTH + TYPE_WIDTH;
  localparam logic [BANK_NUM_WIDTH:0] NUM_BANKS_W = (BANK_NUM_WIDTH + 1)'(NUM_BANKS);

  genvar gi;

  logic [CTRL_WIDTH-1:0]        ctrl_p0;
  logic [CTRL_WIDTH-1:0]        ctrl_p2;
  logic                         sample_clk_en_p2;
  logic [BANK_NUM_WIDTH-1:0]    bank_num_p2;
  logic [OP_NUM_WIDTH-1:0]      op_num_p2;
  logic [TYPE_WIDTH-1:0]        op_type_bits_p2;
  operator_t                    op_type_p2;
  logic                         bank_valid_p2;

  // Slot control rides two register stages to line up with phase_p2; a reset pipeline reads as OP_NORMAL.
  assign ctrl_p0 = {sample_clk_en, bank_num, op_num, op_type_p0};

  pipeline_sr #(
    .WIDTH(CTRL_WIDTH),
    .DEPTH(2)
  ) u_ctrl_sr (
    .clk  (clk),
    .reset(reset),
    .din  (ctrl_p0),
    .dout (ctrl_p2)
  );

  assign {sample_clk_en_p2, bank_num_p2, op_num_p2, op_type_bits_p2} = ctrl_p2;
  assign op_type_p2    = operator_t'(op_type_bits_p2);
  assign bank_valid_p2 = ({1'b0, bank_num_p2} < NUM_BANKS_W);

  logic [NUM_LFSR-1:0] lfsr_step;
  logic [NUM_LFSR-1:0] lfsr_bit0;

  for (gi = 0; gi < NUM_LFSR; gi++) begin : gen_lfsr
    logic [LFSR_WIDTH-1:0] state;
    logic                  unused_state_hi;

    if (SHARED_LFSR) begin : g_shared
      assign lfsr_step[gi] = sample_clk_en && (bank_num == '0) && (op_num == '0);
    end else begin : g_per_bank
      assign lfsr_step[gi] = sample_clk_en && (op_num == '0) &&
                             ({1'b0, bank_num} == (BANK_NUM_WIDTH + 1)'(gi));
    end

    rhythm_noise_lfsr #(
      .POLY (LFSR_POLY),
      .WIDTH(LFSR_WIDTH),
      .SEED (LFSR_SEED)
    ) u_lfsr (
      .clk  (clk),
      .reset(reset),
      .step (lfsr_step[gi]),
      .load (seed_load),
      .state(state)
    );

    assign lfsr_bit0[gi]   = state[0];
    assign unused_state_hi = ^state[LFSR_WIDTH-1:1];
  end

  logic [NUM_BANKS-1:0][PHASE_FINAL_WIDTH-1:0] hh_friend_flat;
  logic [NUM_BANKS-1:0][PHASE_FINAL_WIDTH-1:0] tc_friend_flat;

  // Friends are captured whether or not rhythm mode is on, so enabling it later sees fresh phases.
  for (gi = 0; gi < NUM_BANKS; gi++) begin : gen_friend
    logic [PHASE_FINAL_WIDTH-1:0] hh_friend_reg;
    logic [PHASE_FINAL_WIDTH-1:0] tc_friend_reg;
    logic                         bank_hit;

    assign bank_hit = sample_clk_en_p2 && ({1'b0, bank_num_p2} == (BANK_NUM_WIDTH + 1)'(gi));

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        hh_friend_reg <= '0;
        tc_friend_reg <= '0;
      end else begin
        if (bank_hit && (op_num_p2 == OP_NUM_WIDTH'(HH_OP))) begin
          hh_friend_reg <= phase_p2;
        end
        if (bank_hit && (op_num_p2 == OP_NUM_WIDTH'(TC_OP))) begin
          tc_friend_reg <= phase_p2;
        end
      end
    end

    assign hh_friend_flat[gi] = hh_friend_reg;
    assign tc_friend_flat[gi] = tc_friend_reg;
  end

  logic [PHASE_FINAL_WIDTH-1:0] hh_sel;
  logic [PHASE_FINAL_WIDTH-1:0] tc_sel;
  logic                         bank_rhythm;
  logic                         r_bit;

  always_comb begin
    hh_sel      = '0;
    tc_sel      = '0;
    bank_rhythm = 1'b0;
    r_bit       = 1'b0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if ({1'b0, bank_num_p2} == (BANK_NUM_WIDTH + 1)'(i)) begin
        hh_sel      = hh_friend_flat[i];
        tc_sel      = tc_friend_flat[i];
        bank_rhythm = rhythm_en[i];
      end
    end
    if (bank_valid_p2) begin
      if (SHARED_LFSR) begin
        r_bit = lfsr_bit0[0];
      end else begin
        for (int i = 0; i < NUM_LFSR; i++) begin
          if ({1'b0, bank_num_p2} == (BANK_NUM_WIDTH + 1)'(i)) begin
            r_bit = lfsr_bit0[i];
          end
        end
      end
    end
  end

  logic [PHASE_FINAL_WIDTH-1:0] hh_val;
  logic [PHASE_FINAL_WIDTH-1:0] tc_val;
  logic                         rm;
  logic [PHASE_FINAL_WIDTH-1:0] phase_next;

  always_comb begin
    hh_val     = (op_type_p2 == OP_HI_HAT) ? phase_p2 : hh_sel;
    tc_val     = (op_type_p2 == OP_TOP_CYMBAL) ? phase_p2 : tc_sel;
    rm         = rhythm_mix(hh_val, tc_val);
    phase_next = phase_p2;
    if (bank_rhythm) begin
      case (op_type_p2)
        OP_HI_HAT:     phase_next = {rm, 9'd0} | ((rm ^ r_bit) ? 10'h0d0 : 10'h034);
        OP_SNARE_DRUM: phase_next = {hh_val[8], hh_val[8] ^ r_bit, 8'h00};
        OP_TOP_CYMBAL: phase_next = {rm, 9'h080};
        default:       phase_next = phase_p2;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rhythm_phase_p3 <= '0;
      noise_bit_p3    <= 1'b0;
    end else begin
      rhythm_phase_p3 <= phase_next;
      noise_bit_p3    <= r_bit;
    end
  end

endmodule

// File: tb/tb_calc_rhythm_phase_mb.sv
// tb_calc_rhythm_phase_mb: directed vectors, corner sequences and random slots against a slot-level model,
// driving a shared-LFSR instance and a per-bank-LFSR instance (seed 0) with identical stimulus.
module tb_calc_rhythm_phase_mb;
  import opl3_pkg::*;

  localparam int NB = 2;
  localparam logic [23:0] POLY = 24'h800302;

  typedef struct {
    logic                      en;
    logic [BANK_NUM_WIDTH-1:0] bank;
    logic [OP_NUM_WIDTH-1:0]   op;
    operator_t                 typ;
    logic [9:0]                phase;
    logic [NB-1:0]             ren;
  } slot_t;

  typedef struct {
    string      name;
    slot_t      s;
    logic [9:0] want_phase;
    logic       want_noise;
  } vec_t;

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      sample_clk_en;
  logic [BANK_NUM_WIDTH-1:0] bank_num;
  logic [OP_NUM_WIDTH-1:0]   op_num;
  operator_t                 op_type_p0;
  logic [9:0]                phase_p2;
  logic [NB-1:0]             rhythm_en;
  logic                      seed_load;
  logic [9:0]                phase_sh, phase_pb;
  logic                      noise_sh, noise_pb;

  always #5 clk = ~clk;

  calc_rhythm_phase_mb dut (
    .clk(clk), .reset(reset), .sample_clk_en(sample_clk_en), .bank_num(bank_num),
    .op_num(op_num), .op_type_p0(op_type_p0), .phase_p2(phase_p2), .rhythm_en(rhythm_en),
    .seed_load(seed_load), .rhythm_phase_p3(phase_sh), .noise_bit_p3(noise_sh)
  );

  calc_rhythm_phase_mb #(.SHARED_LFSR(1'b0), .LFSR_SEED(0)) dut_pb (
    .clk(clk), .reset(reset), .sample_clk_en(sample_clk_en), .bank_num(bank_num),
    .op_num(op_num), .op_type_p0(op_type_p0), .phase_p2(phase_p2), .rhythm_en(rhythm_en),
    .seed_load(seed_load), .rhythm_phase_p3(phase_pb), .noise_bit_p3(noise_pb)
  );

  int n_checks = 0;
  int n_fail = 0;

  // Model state: index 0 = shared-LFSR instance (only [0][0] LFSR used), 1 = per-bank instance.
  logic [23:0] m_lfsr [2][NB];
  logic [9:0]  m_hh   [2][NB];
  logic [9:0]  m_tc   [2][NB];
  logic [9:0]  exp_phase [2];
  logic        exp_noise [2];
  slot_t       h1, h2, idle;
  vec_t        vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, want);
    end
  endtask

  function automatic slot_t mk(input logic en, input int bank, input int op, input operator_t typ,
                               input int phase, input int ren);
    slot_t s;
    s.en    = en;
    s.bank  = BANK_NUM_WIDTH'(bank);
    s.op    = OP_NUM_WIDTH'(op);
    s.typ   = typ;
    s.phase = 10'(phase);
    s.ren   = NB'(ren);
    return s;
  endfunction

  function automatic logic [23:0] lfsr_next(input logic [23:0] x);
    return (x % 2 == 1) ? (x ^ POLY) / 2 : x / 2;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int b = 0; b < NB; b++) begin
        m_lfsr[k][b] = 24'd1;
        m_hh[k][b]   = '0;
        m_tc[k][b]   = '0;
      end
    end
    h1 = idle;
    h2 = idle;
  endtask

  // s: slot whose phase arrives now; c: slot entering now; seed: seed_load this cycle.
  task automatic model_eval(input slot_t s, input slot_t c, input logic seed);
    for (int k = 0; k < 2; k++) begin
      int b;
      int res;
      logic r, rm;
      logic [9:0] hh, tc;
      b   = int'(s.bank);
      r   = 1'b0;
      res = int'(s.phase);
      if (b < NB) begin
        r  = (k == 0) ? m_lfsr[k][0][0] : m_lfsr[k][b][0];
        hh = (s.typ == OP_HI_HAT) ? s.phase : m_hh[k][b];
        tc = (s.typ == OP_TOP_CYMBAL) ? s.phase : m_tc[k][b];
        rm = (hh[2] != hh[7]) || (hh[3] != tc[5]) || (tc[3] != tc[5]);
        if (s.ren[b]) begin
          if (s.typ == OP_HI_HAT)
            res = (rm ? 512 : 0) + ((rm != r) ? 'hd0 : 'h34);
          else if (s.typ == OP_SNARE_DRUM)
            res = (hh[8] ? 512 : 0) + ((hh[8] != r) ? 256 : 0);
          else if (s.typ == OP_TOP_CYMBAL)
            res = (rm ? 512 : 0) + 'h80;
        end
        if (s.en && s.op == 13) m_hh[k][b] = s.phase;
        if (s.en && s.op == 17) m_tc[k][b] = s.phase;
      end
      exp_phase[k] = res[9:0];
      exp_noise[k] = r;
      if (seed) begin
        for (int j = 0; j < NB; j++) m_lfsr[k][j] = 24'd1;
      end else if (c.en && c.op == 0 && int'(c.bank) < NB) begin
        if (k == 0) begin
          if (c.bank == 0) m_lfsr[0][0] = lfsr_next(m_lfsr[0][0]);
        end else begin
          m_lfsr[1][int'(c.bank)] = lfsr_next(m_lfsr[1][int'(c.bank)]);
        end
      end
    end
  endtask

  task automatic drive(input slot_t c, input logic seed);
    sample_clk_en = c.en;
    bank_num      = c.bank;
    op_num        = c.op;
    op_type_p0    = c.typ;
    phase_p2      = h2.phase;
    rhythm_en     = h2.ren;
    seed_load     = seed;
  endtask

  task automatic cycle(input slot_t c, input logic seed);
    drive(c, seed);
    model_eval(h2, c, seed);
    @(posedge clk);
    #1;
    check("phase_shared", 32'(phase_sh), 32'(exp_phase[0]));
    check("noise_shared", 32'(noise_sh), 32'(exp_noise[0]));
    check("phase_perbank", 32'(phase_pb), 32'(exp_phase[1]));
    check("noise_perbank", 32'(noise_pb), 32'(exp_noise[1]));
    h2 = h1;
    h1 = c;
  endtask

  task automatic do_reset();
    drive(idle, 1'b0);
    reset = 1'b1;
    #1;
    check("reset_phase_shared", 32'(phase_sh), 32'h0);
    check("reset_noise_shared", 32'(noise_sh), 32'h0);
    check("reset_phase_perbank", 32'(phase_pb), 32'h0);
    check("reset_noise_perbank", 32'(noise_pb), 32'h0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    slot_t c;
    idle = mk(1'b0, 0, 0, OP_NORMAL, 0, 3);
    h1 = idle;
    h2 = idle;
    reset = 1'b0;
    drive(idle, 1'b0);

    vecs[0] = '{"tc_bank1_rhythm_off", mk(1'b1, 1, 17, OP_TOP_CYMBAL, 'h3ff, 1), 10'h3ff, 1'b1};
    vecs[1] = '{"tc_bank0_friends0",   mk(1'b1, 0, 17, OP_TOP_CYMBAL, 'h000, 1), 10'h080, 1'b1};
    vecs[2] = '{"hh_bank0_r1",         mk(1'b1, 0, 13, OP_HI_HAT,     'h004, 3), 10'h234, 1'b1};
    vecs[3] = '{"capture_hh_100",      mk(1'b1, 0, 13, OP_NORMAL,     'h100, 3), 10'h100, 1'b1};
    vecs[4] = '{"sd_friend100",        mk(1'b1, 0, 16, OP_SNARE_DRUM, 'h000, 3), 10'h200, 1'b1};
    vecs[5] = '{"op0_step",            mk(1'b1, 0, 0,  OP_NORMAL,     'h000, 3), 10'h000, 1'b1};
    vecs[6] = '{"sd_after_step",       mk(1'b1, 0, 16, OP_SNARE_DRUM, 'h000, 3), 10'h200, 1'b1};

    #1;
    do_reset();
    check("seed0_lfsr0_is_1", 32'(dut_pb.gen_lfsr[0].u_lfsr.state), 32'h1);
    check("seed0_lfsr1_is_1", 32'(dut_pb.gen_lfsr[1].u_lfsr.state), 32'h1);

    // Directed vectors: each slot followed by two idles so its p3 result is isolated.
    for (int v = 0; v < 7; v++) begin
      cycle(vecs[v].s, 1'b0);
      cycle(idle, 1'b0);
      cycle(idle, 1'b0);
      check(vecs[v].name, 32'(phase_sh), 32'(vecs[v].want_phase));
      check({vecs[v].name, "_noise"}, 32'(noise_sh), 32'(vecs[v].want_noise));
    end

    // LFSR stepping and seed load.
    do_reset();
    cycle(mk(1'b1, 0, 0, OP_NORMAL, 0, 3), 1'b0);
    check("lfsr_first_step", 32'(dut.gen_lfsr[0].u_lfsr.state), 32'h400181);
    cycle(mk(1'b1, 0, 0, OP_NORMAL, 0, 3), 1'b0);
    check("lfsr_second_step", 32'(dut.gen_lfsr[0].u_lfsr.state), 32'(m_lfsr[0][0]));
    cycle(mk(1'b1, 1, 0, OP_NORMAL, 0, 3), 1'b0);
    check("lfsr_no_step_bank1", 32'(dut.gen_lfsr[0].u_lfsr.state), 32'(m_lfsr[0][0]));
    check("lfsr_pb_bank1_step", 32'(dut_pb.gen_lfsr[1].u_lfsr.state), 32'(m_lfsr[1][1]));
    cycle(mk(1'b1, 3, 0, OP_NORMAL, 0, 3), 1'b0);
    check("lfsr_pb_oob_bank0", 32'(dut_pb.gen_lfsr[0].u_lfsr.state), 32'(m_lfsr[1][0]));
    cycle(mk(1'b1, 0, 0, OP_NORMAL, 0, 3), 1'b1);
    check("seed_load_over_step", 32'(dut.gen_lfsr[0].u_lfsr.state), 32'h1);
    check("seed_load_pb", 32'(dut_pb.gen_lfsr[0].u_lfsr.state), 32'h1);
    cycle(idle, 1'b0);
    cycle(idle, 1'b0);

    // Reset while an HH slot is in flight; friend captured earlier must be cleared.
    cycle(mk(1'b1, 0, 13, OP_NORMAL, 'h3ff, 3), 1'b0);
    cycle(idle, 1'b0);
    cycle(idle, 1'b0);
    cycle(mk(1'b1, 0, 13, OP_HI_HAT, 'h084, 3), 1'b0);
    cycle(idle, 1'b0);
    do_reset();
    cycle(mk(1'b1, 0, 16, OP_SNARE_DRUM, 0, 3), 1'b0);
    cycle(idle, 1'b0);
    cycle(idle, 1'b0);
    check("sd_after_midreset", 32'(phase_sh), 32'h100);

    // Random slots against the model, with one reset in the middle.
    for (int i = 0; i < 1500; i++) begin
      int pick;
      if (i == 700) do_reset();
      pick    = int'($urandom_range(0, 4));
      c.en    = ($urandom_range(0, 3) != 0);
      c.bank  = BANK_NUM_WIDTH'($urandom_range(0, 3));
      c.op    = (pick == 0) ? 5'd0 : (pick == 1) ? 5'd13 : (pick == 2) ? 5'd16 :
                (pick == 3) ? 5'd17 : OP_NUM_WIDTH'($urandom_range(0, 31));
      c.typ   = operator_t'($urandom_range(0, 5));
      c.phase = 10'($urandom);
      c.ren   = NB'($urandom);
      cycle(c, ($urandom_range(0, 63) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
